// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, bus widths, instruction field slices and fetch state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned OPC_W   = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_LW   = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SW   = 4'b1010;
    localparam logic [OPC_W-1:0] OP_BNE  = 4'b1110;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RS_MSB  = 11;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned RT_MSB  = 7;
    localparam int unsigned RT_LSB  = 4;
    localparam int unsigned RD_MSB  = 3;
    localparam int unsigned RD_LSB  = 0;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } id_entry_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode valid/ready handshake carrying the fetched instruction and its address.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;

    modport master (output id_valid, output id_instr, output id_pc, input id_ready);
    modport slave  (input id_valid, input id_instr, input id_pc, output id_ready);
endinterface

// File: rtl/pc_counter.sv
// Program counter: redirect load, increment modulo DEPTH, or hold.
module pc_counter
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned       DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // DEPTH is a power of two, so masking implements the modulo
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc & PC_MASK;
        end else if (inc) begin
            pc_d = (pc_q + ADDR_W'(1)) & PC_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives imem address, registers IF/ID entry, handles redirect and HALT.
// Optional PERF_CNT_EN adds a 32-bit fetch_count output counting every fetch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter int unsigned       IMEM_DEPTH = 16,
    parameter logic [OPC_W-1:0]  HALT_OP    = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    fetch_stage_if.master       id_bus,
    output logic                halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count
`endif
);

    localparam logic [0:0] ST_RUN  = 1'(FS_RUN);
    localparam logic [0:0] ST_HALT = 1'(FS_HALT);

    logic [0:0]        state_q, state_d;
    logic              id_valid_q, id_valid_d;
    id_entry_t         id_q, id_d;
    logic [ADDR_W-1:0] pc;
    logic              fire_c;
    logic              halt_op_c;

    assign fire_c    = (state_q == ST_RUN) && !redirect_valid && (!id_valid_q || id_bus.id_ready);
    assign halt_op_c = (opcode_of(imem_instr) == HALT_OP);

    pc_counter #(
        .RESET_PC (RESET_PC),
        .DEPTH    (IMEM_DEPTH)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (fire_c && !halt_op_c),
        .pc      (pc)
    );

    // Next state: redirect beats fire, fire beats drain; a stall holds everything
    always_comb begin
        state_d    = state_q;
        id_valid_d = id_valid_q;
        id_d       = id_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else if (fire_c) begin
            id_valid_d = 1'b1;
            id_d.instr = imem_instr;
            id_d.pc    = pc;
            if (halt_op_c) begin
                state_d = ST_HALT;
            end
        end else if (id_valid_q && id_bus.id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            id_valid_q <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_q       <= id_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (fire_c) begin
            fetch_count_d = fetch_count_q + 32'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign imem_addr       = pc;
    assign halted          = (state_q == ST_HALT);
    assign id_bus.id_valid = id_valid_q;
    assign id_bus.id_instr = id_q.instr;
    assign id_bus.id_pc    = id_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: run, stall, redirect, wrap, mask, halt and reset-in-stall.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [15:0] mem [16];
    int          checks   = 0;
    int          failures = 0;
`ifdef PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    fetch_stage_if id_if ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_bus         (id_if),
        .halted         (halted)
`ifdef PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[3:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        id_if.id_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (id_if.id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", id_if.id_valid); end
        checks++; if (id_if.id_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h expected 0000", id_if.id_instr); end
        checks++; if (id_if.id_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h expected 0000", id_if.id_pc); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_run();
        logic [15:0] exp_instr [4];
        exp_instr[0] = 16'h8123; exp_instr[1] = 16'h8456; exp_instr[2] = 16'h2789; exp_instr[3] = 16'h6abc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (id_if.id_valid !== 1'b1) begin failures++; $display("FAIL run_valid[%0d]: got %b expected 1", i, id_if.id_valid); end
            checks++; if (id_if.id_pc !== 16'(i)) begin failures++; $display("FAIL run_pc[%0d]: got %h expected %h", i, id_if.id_pc, 16'(i)); end
            checks++; if (id_if.id_instr !== exp_instr[i]) begin failures++; $display("FAIL run_instr[%0d]: got %h expected %h", i, id_if.id_instr, exp_instr[i]); end
        end
`ifdef PERF_CNT_EN
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL run_count: got %0d expected 4", fetch_count); end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        tick();
        id_if.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (id_if.id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, id_if.id_valid); end
            checks++; if (id_if.id_pc !== 16'h0002) begin failures++; $display("FAIL stall_pc[%0d]: got %h expected 0002", i, id_if.id_pc); end
            checks++; if (id_if.id_instr !== 16'h2789) begin failures++; $display("FAIL stall_instr[%0d]: got %h expected 2789", i, id_if.id_instr); end
            checks++; if (imem_addr !== 16'h0003) begin failures++; $display("FAIL stall_addr[%0d]: got %h expected 0003", i, imem_addr); end
        end
`ifdef PERF_CNT_EN
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_count: got %0d expected 3", fetch_count); end
`endif
        id_if.id_ready = 1'b1;
        tick();
        checks++; if (id_if.id_valid !== 1'b1 || id_if.id_pc !== 16'h0003) begin failures++; $display("FAIL stall_release: got valid=%b pc=%h expected valid=1 pc=0003", id_if.id_valid, id_if.id_pc); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0007;
        tick();
        redirect_valid = 1'b0;
        checks++; if (id_if.id_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got %b expected 0", id_if.id_valid); end
        checks++; if (imem_addr !== 16'h0007) begin failures++; $display("FAIL redir_addr: got %h expected 0007", imem_addr); end
        tick();
        checks++; if (id_if.id_valid !== 1'b1 || id_if.id_pc !== 16'h0007) begin failures++; $display("FAIL redir_target: got valid=%b pc=%h expected valid=1 pc=0007", id_if.id_valid, id_if.id_pc); end
        checks++; if (id_if.id_instr !== 16'hE000) begin failures++; $display("FAIL redir_instr: got %h expected e000", id_if.id_instr); end
    endtask

    task automatic test_wrap_mask();
        for (int i = 8; i < 16; i++) begin
            tick();
            checks++; if (id_if.id_pc !== 16'(i)) begin failures++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, id_if.id_pc, 16'(i)); end
        end
        tick();
        checks++; if (id_if.id_pc !== 16'h0000 || id_if.id_instr !== 16'h8123) begin failures++; $display("FAIL wrap: got pc=%h instr=%h expected pc=0000 instr=8123", id_if.id_pc, id_if.id_instr); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0013;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 16'h0003) begin failures++; $display("FAIL mask_addr: got %h expected 0003", imem_addr); end
        tick();
        checks++; if (id_if.id_pc !== 16'h0003 || id_if.id_instr !== 16'h6abc) begin failures++; $display("FAIL mask_fetch: got pc=%h instr=%h expected pc=0003 instr=6abc", id_if.id_pc, id_if.id_instr); end
    endtask

    task automatic test_halt();
        mem[4] = 16'hF000;
        tick();
        checks++; if (id_if.id_valid !== 1'b1 || id_if.id_pc !== 16'h0004) begin failures++; $display("FAIL halt_deliver: got valid=%b pc=%h expected valid=1 pc=0004", id_if.id_valid, id_if.id_pc); end
        checks++; if (id_if.id_instr !== 16'hF000) begin failures++; $display("FAIL halt_instr: got %h expected f000", id_if.id_instr); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_state: got %b expected 1", halted); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (id_if.id_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL halt_idle[%0d]: got valid=%b halted=%b expected valid=0 halted=1", i, id_if.id_valid, halted); end
            checks++; if (imem_addr !== 16'h0004) begin failures++; $display("FAIL halt_pc[%0d]: got %h expected 0004", i, imem_addr); end
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || id_if.id_valid !== 1'b0) begin failures++; $display("FAIL halt_exit: got halted=%b valid=%b expected 0 0", halted, id_if.id_valid); end
        tick();
        checks++; if (id_if.id_valid !== 1'b1 || id_if.id_pc !== 16'h0000) begin failures++; $display("FAIL halt_resume: got valid=%b pc=%h expected valid=1 pc=0000", id_if.id_valid, id_if.id_pc); end
        // Redirect arriving together with a HALT opcode keeps the stage running
        redirect_valid = 1'b1;
        redirect_pc = 16'h0004;
        tick();
        redirect_pc = 16'h0005;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || imem_addr !== 16'h0005) begin failures++; $display("FAIL redir_vs_halt: got halted=%b addr=%h expected halted=0 addr=0005", halted, imem_addr); end
        tick();
        checks++; if (id_if.id_pc !== 16'h0005 || id_if.id_instr !== 16'h7111) begin failures++; $display("FAIL redir_vs_halt_fetch: got pc=%h instr=%h expected pc=0005 instr=7111", id_if.id_pc, id_if.id_instr); end
        mem[4] = 16'h0000;
    endtask

    task automatic test_reset_in_stall();
        id_if.id_ready = 1'b0;
        tick();
        checks++; if (id_if.id_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid: got %b expected 1", id_if.id_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        id_if.id_ready = 1'b1;
        checks++; if (id_if.id_valid !== 1'b0 || imem_addr !== 16'h0000 || halted !== 1'b0) begin failures++; $display("FAIL rst_stall: got valid=%b addr=%h halted=%b expected 0 0000 0", id_if.id_valid, imem_addr, halted); end
`ifdef PERF_CNT_EN
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", fetch_count); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h8123; mem[1] = 16'h8456; mem[2] = 16'h2789; mem[3] = 16'h6abc;
        mem[4] = 16'h0000; mem[5] = 16'h7111; mem[6] = 16'hA222; mem[7] = 16'hE000;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        id_if.id_ready = 1'b1;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_wrap_mask();
        test_halt();
        test_reset_in_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the combinational instruction memory (16 x 16-bit, word-addressed). Holds the program counter, drives the memory address, and registers the returned instruction into an IF/ID pipeline register. Hands the instruction to decode with a valid/ready handshake. Handles branch redirect/flush and a HALT opcode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
IMEM_DEPTH, 16, instruction memory entries; power of two; PC increments modulo IMEM_DEPTH.
HALT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
imem_addr  output  16  address to instruction memory; combinationally equals pc.
imem_instr  input  16  instruction from memory; same-cycle combinational read.
redirect_valid  input  1  branch/jump taken this cycle; flush and reload PC.
redirect_pc  input  16  redirect target, word address.
id_ready  input  1  decode can accept id_* this cycle.
id_valid  output  1  id_instr/id_pc hold a valid instruction.
id_instr  output  16  fetched instruction: opcode[15:12], rs[11:8], rt[7:4], rd[3:0].
id_pc  output  16  address id_instr was fetched from.
halted  output  1  high while FSM is in HALT.

Behaviour:
- Reset (rst=1 at clock edge): pc=RESET_PC, id_valid=0, id_instr=16'h0000, id_pc=16'h0000, state=RUN, halted=0. Reset has priority over all other inputs and aborts any in-flight operation.
- imem_addr = pc at all times; no registered delay.
- FSM states: RUN, HALT. halted = (state==HALT).
- fire = (state==RUN) && !redirect_valid && (!id_valid || id_ready).
- Priority at each edge: rst > redirect_valid > fire > drain.
- Redirect:
  - pc <= redirect_pc & (IMEM_DEPTH-1).
  - id_valid <= 0; the instruction currently held is dropped even if id_ready=1.
  - state <= RUN; this exits HALT.
  - The target instruction appears with id_valid=1 two cycles after the redirect cycle.
- Fire:
  - id_instr <= imem_instr, id_pc <= pc, id_valid <= 1.
  - If imem_instr[15:12]==HALT_OP: pc holds and state <= HALT. The HALT instruction itself is still delivered to decode.
  - Otherwise pc <= (pc+1) & (IMEM_DEPTH-1), so pc wraps from IMEM_DEPTH-1 to 0.
- Drain (no fire, no redirect): if id_valid && id_ready then id_valid <= 0.
- Stall: if id_valid && !id_ready, then id_instr, id_pc, id_valid and pc all hold. No instruction is lost or duplicated.
- Latency: with rst low in cycle 0 and id_ready=1, the edge ending cycle 0 fetches RESET_PC, id_valid=1 in cycle 1. Steady state is one instruction per cycle.
- HALT: no fetch, pc frozen. The last id_* entry drains normally. Only redirect or rst leaves HALT.
- If redirect_valid and a HALT opcode arrive in the same cycle, redirect wins; state stays RUN.

Optional Feature:
PERF_CNT_EN:
- Defined: adds output fetch_count (32 bits). Reset to 0; increments by 1 on every fire; wraps at 2^32; holds during stall and HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_ADD=4'b0010, OP_SUB=4'b0110, OP_SLT=4'b0111, OP_LW=4'b1000, OP_SW=4'b1010, OP_BNE=4'b1110, OP_HALT=4'b1111);
  - INSTR_W=16, ADDR_W=16;
  - fetch state enum {RUN, HALT};
  - instruction field slice constants.
- One natural sub-module, pc_counter: holds pc, with load (redirect), increment-modulo-depth (fire) and hold.

Test Plan:
- Reset then run with id_ready=1, memory preloaded with opcodes 8,8,2,6 -> id_pc=0,1,2,3 on cycles 1-4, id_instr matches memory, id_valid continuous.
- id_ready=0 for 3 cycles while id_pc=2 -> id_instr/id_pc/imem_addr frozen (imem_addr=3). On release, id_pc=2 consumed, then 3 follows with no gap.
- redirect_valid=1 with redirect_pc=7 while id_pc=3 valid -> id_valid=0 next cycle, then id_pc=7 with instruction mem[7] (16'hE000).
- Sequential fetch through pc=15 -> next id_pc=0 (wrap). redirect_pc=16'h0013 -> pc=3 (masked).
- mem[4]=16'hF000 -> delivered with id_pc=4; halted=1 next cycle; no further id_valid. A later redirect_pc=0 -> halted=0 and fetch resumes at 0.
- Assert rst mid-stall with id_valid=1 -> next cycle id_valid=0, pc=0, halted=0, fetch_count=0 (with PERF_CNT_EN).
